mem_ctl_arbiter: RTL and testbench

- Synchronous front end that shares one memory controller between two requesters.
- The controller uses a four-phase handshake: din_valid/din_ack, wen, dout_valid/dout_ack.
- Arbitrates round-robin and sequences the full handshake per transaction.
- Synchronizes the controller's self-timed ack/valid lines into the clock domain.
- Bounds every wait with a timeout watchdog; on expiry, reports an error response to the requester.

---
 rtl/mem_ctl_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_ctl_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctl_arbiter.sv
// Round-robin front end that shares one four-phase memory controller between two
// requesters, with 2-flop synchronizers on the controller's self-timed lines and a watchdog.
module mem_ctl_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wen,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wen,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mc_din_valid,
  output logic              mc_wen,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [DATA_W-1:0] mc_wdata,
  input  logic              mc_din_ack,
  input  logic              mc_dout_valid,
  input  logic [DATA_W-1:0] mc_rdata,
  output logic              mc_dout_ack,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, RELEASE, WAIT_RD, RD_ACK, DONE, ERR, ERR_RSP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_s1_q, ack_s_q, dv_s1_q, dv_s_q;
  logic              last_grant_q, last_grant_d;
  logic              port_q, port_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              can_grant, grant0, grant1, expired, wd_state, drive_mc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_s1_q <= 1'b0;
      ack_s_q  <= 1'b0;
      dv_s1_q  <= 1'b0;
      dv_s_q   <= 1'b0;
    end else begin
      ack_s1_q <= mc_din_ack;
      ack_s_q  <= ack_s1_q;
      dv_s1_q  <= mc_dout_valid;
      dv_s_q   <= dv_s1_q;
    end
  end

  // last_grant resets to 1 so that port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    can_grant    = rst && (state_q == IDLE) && !ack_s_q && !dv_s_q;
    grant0       = can_grant && req0_valid && (!req1_valid || last_grant_q);
    grant1       = can_grant && req1_valid && (!req0_valid || !last_grant_q);
    expired      = (cnt_q == CNT_W'(TIMEOUT_CYC));
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    req0_ready   = grant0;
    req1_ready   = grant1;
    mc_din_valid = 1'b0;
    mc_dout_ack  = 1'b0;
    rsp0_valid   = 1'b0;
    rsp0_err     = 1'b0;
    rsp1_valid   = 1'b0;
    rsp1_err     = 1'b0;

    // In every waiting state the normal exit is tested before expiry, so it wins a tie
    case (state_q)
      IDLE: begin
        if (grant0) begin
          port_d       = 1'b0;
          last_grant_d = 1'b0;
          wen_d        = req0_wen;
          addr_d       = req0_addr;
          wdata_d      = req0_wdata;
          state_d      = ISSUE;
        end else if (grant1) begin
          port_d       = 1'b1;
          last_grant_d = 1'b1;
          wen_d        = req1_wen;
          addr_d       = req1_addr;
          wdata_d      = req1_wdata;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        mc_din_valid = 1'b1;
        if (ack_s_q)      state_d = RELEASE;
        else if (expired) state_d = ERR;
      end
      RELEASE: begin
        if (!ack_s_q)     state_d = wen_q ? DONE : WAIT_RD;
        else if (expired) state_d = ERR;
      end
      WAIT_RD: begin
        if (dv_s_q) begin
          rdata_d = mc_rdata;
          state_d = RD_ACK;
        end else if (expired) begin
          state_d = ERR;
        end
      end
      RD_ACK: begin
        mc_dout_ack = 1'b1;
        if (!dv_s_q)      state_d = DONE;
        else if (expired) state_d = ERR;
      end
      DONE: begin
        rsp0_valid = !port_q;
        rsp1_valid = port_q;
        state_d    = IDLE;
      end
      ERR: begin
        if (!ack_s_q && !dv_s_q) state_d = ERR_RSP;
      end
      ERR_RSP: begin
        rsp0_valid = !port_q;
        rsp0_err   = !port_q;
        rsp1_valid = port_q;
        rsp1_err   = port_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wd_state = (state_d == ISSUE) || (state_d == RELEASE) ||
               (state_d == WAIT_RD) || (state_d == RD_ACK);
    cnt_d    = (wd_state && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;
  end

  assign drive_mc  = (state_q == ISSUE) || (state_q == RELEASE);
  assign mc_wen    = drive_mc ? wen_q : 1'b0;
  assign mc_addr   = drive_mc ? addr_q : '0;
  assign mc_wdata  = drive_mc ? wdata_q : '0;
  assign rsp_rdata = (state_q == ERR_RSP) ? '0 : rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_ctl_arbiter.sv
// Directed bench for mem_ctl_arbiter against a zero-delay four-phase controller model;
// cycle offsets are relative to the accept cycle t of each transaction.
module tb_mem_ctl_arbiter;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready, req0_wen;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              rsp0_valid, rsp0_err;
  logic              req1_valid, req1_ready, req1_wen;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp1_valid, rsp1_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mc_din_valid, mc_wen, mc_din_ack, mc_dout_valid, mc_dout_ack, busy;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_wdata, mc_rdata;

  logic              ackEn     = 1'b1;
  logic              modelRead = 1'b0;
  logic              dvRaw     = 1'b0;
  logic [DATA_W-1:0] modelData = '0;

  int nCompared   = 0;
  int nMismatched = 0;

  mem_ctl_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wen(req0_wen),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wen(req1_wen),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err),
    .rsp_rdata(rsp_rdata),
    .mc_din_valid(mc_din_valid), .mc_wen(mc_wen), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_din_ack(mc_din_ack), .mc_dout_valid(mc_dout_valid), .mc_rdata(mc_rdata),
    .mc_dout_ack(mc_dout_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // Controller model: ack mirrors the request; read data appears as ack falls, leaves on dout_ack
  assign mc_din_ack    = mc_din_valid & ackEn;
  assign mc_dout_valid = dvRaw;
  assign mc_rdata      = modelData;

  always @(negedge mc_din_ack) if (modelRead) dvRaw = 1'b1;
  always @(posedge mc_dout_ack) dvRaw = 1'b0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 60) begin
      tick();
      n++;
    end
    nCompared++;
    if (busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL %s_idle: busy=%b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req0_wen = 1'b1; req0_addr = 8'h01; req0_wdata = 8'h11; req0_valid = 1'b1;
    req1_wen = 1'b1; req1_addr = 8'h02; req1_wdata = 8'h22; req1_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      nCompared++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err,
           mc_din_valid, mc_wen, mc_dout_ack, busy, rsp_rdata, mc_addr, mc_wdata} !== 34'd0) begin
        nMismatched++;
        $display("[TB] FAIL reset_outputs: ready=%b%b rsp=%b%b%b%b mc=%b%b%b busy=%b rdata=%h addr=%h wdata=%h expected all 0",
                 req0_ready, req1_ready, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err,
                 mc_din_valid, mc_wen, mc_dout_ack, busy, rsp_rdata, mc_addr, mc_wdata);
      end
    end
    rst = 1'b1;
    #1;
    nCompared++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL reset_first_grant: ready0/1=%b%b expected 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    waitIdle("reset");
  endtask

  task automatic test_single_write();
    req0_wen = 1'b1; req0_addr = 8'h12; req0_wdata = 8'hA5; req0_valid = 1'b1;
    #1;
    nCompared++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL write_accept: ready0/1=%b%b expected 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      nCompared++;
      if ({mc_din_valid, mc_wen, mc_addr, mc_wdata} !== {1'b1, 1'b1, 8'h12, 8'hA5}) begin
        nMismatched++;
        $display("[TB] FAIL write_issue_t%0d: dv=%b wen=%b addr=%h wdata=%h expected 1 1 12 a5",
                 k, mc_din_valid, mc_wen, mc_addr, mc_wdata);
      end
      tick();
    end
    for (int k = 4; k <= 6; k++) begin
      nCompared++;
      if ({mc_din_valid, rsp0_valid, rsp1_valid} !== 3'b000) begin
        nMismatched++;
        $display("[TB] FAIL write_wait_t%0d: dv=%b rsp0=%b rsp1=%b expected 000",
                 k, mc_din_valid, rsp0_valid, rsp1_valid);
      end
      tick();
    end
    nCompared++;
    if ({rsp0_valid, rsp0_err, rsp1_valid} !== 3'b100) begin
      nMismatched++;
      $display("[TB] FAIL write_rsp_t7: rsp0=%b err0=%b rsp1=%b expected 100",
               rsp0_valid, rsp0_err, rsp1_valid);
    end
    tick();
    nCompared++;
    if ({rsp0_valid, busy} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL write_end_t8: rsp0=%b busy=%b expected 00", rsp0_valid, busy);
    end
  endtask

  task automatic test_single_read();
    modelRead = 1'b1; modelData = 8'h5C;
    req1_wen = 1'b0; req1_addr = 8'h34; req1_wdata = 8'h00; req1_valid = 1'b1;
    #1;
    nCompared++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      nMismatched++;
      $display("[TB] FAIL read_accept: ready0/1=%b%b expected 01", req0_ready, req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      nCompared++;
      if ({mc_din_valid, mc_wen, mc_addr} !== {1'b1, 1'b0, 8'h34}) begin
        nMismatched++;
        $display("[TB] FAIL read_issue_t%0d: dv=%b wen=%b addr=%h expected 1 0 34",
                 k, mc_din_valid, mc_wen, mc_addr);
      end
      tick();
    end
    for (int k = 4; k <= 10; k++) begin
      nCompared++;
      if ({mc_dout_ack, rsp1_valid} !== {(k >= 8), 1'b0}) begin
        nMismatched++;
        $display("[TB] FAIL read_dout_ack_t%0d: dout_ack=%b rsp1=%b expected %b0",
                 k, mc_dout_ack, rsp1_valid, (k >= 8));
      end
      tick();
    end
    nCompared++;
    if ({rsp1_valid, rsp1_err, rsp0_valid, rsp_rdata} !== {3'b100, 8'h5C}) begin
      nMismatched++;
      $display("[TB] FAIL read_rsp_t11: rsp1=%b err1=%b rsp0=%b rdata=%h expected 1 0 0 5c",
               rsp1_valid, rsp1_err, rsp0_valid, rsp_rdata);
    end
    tick();
    modelRead = 1'b0;
    nCompared++;
    if ({rsp1_valid, busy} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL read_end_t12: rsp1=%b busy=%b expected 00", rsp1_valid, busy);
    end
  endtask

  task automatic test_contention();
    int order[4] = '{0, 1, 0, 1};
    req0_wen = 1'b1; req0_addr = 8'h40; req0_wdata = 8'h0F; req0_valid = 1'b1;
    req1_wen = 1'b1; req1_addr = 8'h41; req1_wdata = 8'hF0; req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (req0_ready !== 1'b1 && req1_ready !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      nCompared++;
      if ({req0_ready, req1_ready} !== ((order[i] == 0) ? 2'b10 : 2'b01)) begin
        nMismatched++;
        $display("[TB] FAIL contention_grant%0d: ready0/1=%b%b expected port %0d",
                 i, req0_ready, req1_ready, order[i]);
      end
      if (i > 0) begin
        nCompared++;
        if (n != 7) begin
          nMismatched++;
          $display("[TB] FAIL contention_gap%0d: waited %0d cycles expected 7", i, n);
        end
      end
      tick();
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      nCompared++;
      if ({req0_ready, req1_ready, mc_din_valid} !== 3'b001) begin
        nMismatched++;
        $display("[TB] FAIL contention_pulse%0d: ready0/1=%b%b dv=%b expected 001",
                 i, req0_ready, req1_ready, mc_din_valid);
      end
    end
    waitIdle("contention");
  endtask

  task automatic test_timeout();
    ackEn = 1'b0;
    req0_wen = 1'b1; req0_addr = 8'h56; req0_wdata = 8'h77; req0_valid = 1'b1;
    #1;
    nCompared++;
    if (req0_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL timeout_accept: ready0=%b expected 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      nCompared++;
      if (mc_din_valid !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL timeout_issue_t%0d: dv=%b expected 1", k, mc_din_valid);
      end
      tick();
    end
    nCompared++;
    if ({mc_din_valid, rsp0_valid, busy} !== 3'b001) begin
      nMismatched++;
      $display("[TB] FAIL timeout_err_t18: dv=%b rsp0=%b busy=%b expected 001",
               mc_din_valid, rsp0_valid, busy);
    end
    tick();
    nCompared++;
    if ({rsp0_valid, rsp0_err, rsp1_valid, rsp_rdata} !== {3'b110, 8'h00}) begin
      nMismatched++;
      $display("[TB] FAIL timeout_rsp_t19: rsp0=%b err0=%b rsp1=%b rdata=%h expected 1 1 0 00",
               rsp0_valid, rsp0_err, rsp1_valid, rsp_rdata);
    end
    tick();
    ackEn = 1'b1;
    nCompared++;
    if (busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL timeout_idle_t20: busy=%b expected 0", busy);
    end
    req1_wen = 1'b1; req1_addr = 8'h57; req1_wdata = 8'h88; req1_valid = 1'b1;
    #1;
    nCompared++;
    if (req1_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL recover_accept: ready1=%b expected 1", req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    for (int k = 1; k < 7; k++) tick();
    nCompared++;
    if ({rsp1_valid, rsp1_err} !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL recover_rsp_t7: rsp1=%b err1=%b expected 10", rsp1_valid, rsp1_err);
    end
    waitIdle("recover");
  endtask

  task automatic test_reset_mid_read();
    modelRead = 1'b1; modelData = 8'h3C;
    req0_wen = 1'b0; req0_addr = 8'h78; req0_wdata = 8'h00; req0_valid = 1'b1;
    #1;
    tick();
    req0_valid = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    nCompared++;
    if (mc_dout_ack !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL midrst_rd_ack_t8: dout_ack=%b expected 1", mc_dout_ack);
    end
    rst = 1'b0;
    tick();
    nCompared++;
    if ({mc_dout_ack, mc_din_valid, busy, rsp0_valid, rsp_rdata} !== 12'h000) begin
      nMismatched++;
      $display("[TB] FAIL midrst_drop: dout_ack=%b dv=%b busy=%b rsp0=%b rdata=%h expected all 0",
               mc_dout_ack, mc_din_valid, busy, rsp0_valid, rsp_rdata);
    end
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      nCompared++;
      if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
        nMismatched++;
        $display("[TB] FAIL midrst_no_rsp%0d: rsp0=%b rsp1=%b expected 00", k, rsp0_valid, rsp1_valid);
      end
    end
    modelData = 8'h9E;
    req0_addr = 8'h79; req0_valid = 1'b1;
    #1;
    nCompared++;
    if (req0_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL midrst_reaccept: ready0=%b expected 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    for (int k = 1; k < 11; k++) tick();
    nCompared++;
    if ({rsp0_valid, rsp0_err, rsp_rdata} !== {2'b10, 8'h9E}) begin
      nMismatched++;
      $display("[TB] FAIL midrst_read_t11: rsp0=%b err0=%b rdata=%h expected 1 0 9e",
               rsp0_valid, rsp0_err, rsp_rdata);
    end
    modelRead = 1'b0;
    waitIdle("midrst");
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req0_wen = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_wen = 1'b0; req1_addr = '0; req1_wdata = '0;
    $display("[TB] starting mem_ctl_arbiter bench");
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_timeout();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
